button_driver: RTL and testbench

- Memory-mapped input peripheral on the IO side of BUS; the read-direction counterpart to LedDriver and DigitDriver.
- Synchronises and debounces N push-buttons.
- Latches press events as sticky W1C flags and keeps a press counter, so polling firmware on miniCPU never misses a short press.
- Runs on the 100 MHz board clock. Read data is combinational so BUS can mux it in the same cycle.

---
 rtl/button_driver.sv | 109 ++++++++++
 tb/tb_button_driver.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_driver.sv
// button_driver: synchronised, debounced push-buttons on the IO bus.
// Sticky W1C press flags and a 16-bit press counter for polling firmware.
module button_driver #(
  parameter int          N_BTN      = 5,
  parameter int          DEB_CYCLES = 1000000,
  parameter logic [11:0] ADDR_LEVEL = 12'h070,
  parameter logic [11:0] ADDR_EVENT = 12'h074,
  parameter logic [11:0] ADDR_COUNT = 12'h078
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             io_en,
  input  logic             io_we,
  input  logic [11:0]      io_addr,
  input  logic [31:0]      io_write_data,
  output logic [31:0]      io_read_data,
  input  logic [N_BTN-1:0] device_btn
);

  localparam logic [19:0] DEB_LAST = 20'(DEB_CYCLES - 1);

  logic [N_BTN-1:0] s1;
  logic [N_BTN-1:0] sync;
  logic [N_BTN-1:0] stable;
  logic [N_BTN-1:0] stable_q;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] evt;
  logic [N_BTN-1:0] clr;
  logic [19:0]      cnt [N_BTN];
  logic [15:0]      count;
  logic [4:0]       n_press;
  logic             rd;
  logic             wr_evt;
  logic             wr_cnt;
  logic             unused_wdata;

  assign unused_wdata = ^io_write_data[31:N_BTN];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1       <= '0;
      sync     <= '0;
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < N_BTN; i++)
        cnt[i] <= '0;
    end else begin
      s1       <= device_btn;
      sync     <= s1;
      stable_q <= stable;
      for (int i = 0; i < N_BTN; i++) begin
        if (sync[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          stable[i] <= sync[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 20'd1;
        end
      end
    end
  end

  assign press  = stable & ~stable_q;
  assign rd     = io_en & ~io_we;
  assign wr_evt = io_en & io_we &
                  (io_addr == ADDR_EVENT);
  assign wr_cnt = io_en & io_we &
                  (io_addr == ADDR_COUNT);
  assign clr    = wr_evt ?
                  io_write_data[N_BTN-1:0] : '0;

  always_comb begin
    n_press = '0;
    for (int i = 0; i < N_BTN; i++)
      n_press = n_press + 5'(press[i]);
  end

  // Set beats clear; a counter clear keeps this cycle's presses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt   <= '0;
      count <= '0;
    end else begin
      evt <= (evt & ~clr) | press;
      if (wr_cnt)
        count <= 16'(n_press);
      else
        count <= count + 16'(n_press);
    end
  end

  always_comb begin
    io_read_data = '0;
    if (rd) begin
      unique case (1'b1)
        (io_addr == ADDR_LEVEL):
          io_read_data = 32'(stable);
        (io_addr == ADDR_EVENT):
          io_read_data = 32'(evt);
        (io_addr == ADDR_COUNT):
          io_read_data = {16'h0, count};
        default:
          io_read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_button_driver.sv
// tb_button_driver: table vectors, corner sequences and a
// random phase checked against a sample-window reference model.
module tb_button_driver;

  localparam int DEB = 4;
  localparam int NB  = 16;

  logic        clk;
  logic        rst_n;
  logic        io_en;
  logic        io_we;
  logic [11:0] io_addr;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;
  logic [NB-1:0] device_btn;

  int n_vec = 0;
  int n_bad = 0;

  button_driver #(
    .N_BTN(NB),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io_en(io_en),
    .io_we(io_we),
    .io_addr(io_addr),
    .io_write_data(io_write_data),
    .io_read_data(io_read_data),
    .device_btn(device_btn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a level flips once the last DEB samples seen through
  // the two-flop delay all disagree with it; a rise is a press.
  logic [15:0] m_lvl = '0;
  logic [15:0] m_evt = '0;
  logic [15:0] m_cnt = '0;
  logic [15:0] m_rise = '0;
  logic [15:0] hist[$];

  always @(posedge clk) begin
    logic [15:0] nl;
    bit all;
    if (!rst_n) begin
      m_lvl = '0;
      m_evt = '0;
      m_cnt = '0;
      m_rise = '0;
      hist.delete();
      repeat (8) hist.push_back('0);
    end else begin
      if (io_en && io_we && io_addr == 12'h074)
        m_evt = m_evt & ~io_write_data[15:0];
      m_evt = m_evt | m_rise;
      if (io_en && io_we && io_addr == 12'h078)
        m_cnt = 16'($countones(m_rise));
      else
        m_cnt = m_cnt + 16'($countones(m_rise));
      nl = m_lvl;
      for (int i = 0; i < NB; i++) begin
        all = 1'b1;
        for (int j = 0; j < DEB; j++)
          if (hist[1+j][i] == m_lvl[i]) all = 1'b0;
        if (all) nl[i] = ~m_lvl[i];
      end
      m_rise = nl & ~m_lvl;
      m_lvl = nl;
      hist.push_front(device_btn);
      void'(hist.pop_back());
    end
  end

  function automatic logic [31:0] exp_rd(
    input logic [11:0] a);
    case (a)
      12'h070: return {16'h0, m_lvl};
      12'h074: return {16'h0, m_evt};
      12'h078: return {16'h0, m_cnt};
      default: return 32'h0;
    endcase
  endfunction

  task automatic rd(input string nm,
                    input logic [11:0] a,
                    input logic [31:0] exp);
    io_en = 1'b1;
    io_we = 1'b0;
    io_addr = a;
    #1;
    n_vec++;
    if (io_read_data !== exp) begin
      n_bad++;
      $display("FAIL %s: addr %h got %h want %h",
               nm, a, io_read_data, exp);
    end
  endtask

  task automatic wr(input logic [11:0] a,
                    input logic [31:0] d);
    io_en = 1'b1;
    io_we = 1'b1;
    io_addr = a;
    io_write_data = d;
    @(negedge clk);
    io_en = 1'b0;
    io_we = 1'b0;
  endtask

  task automatic hold(input logic [15:0] b,
                      input int n);
    io_en = 1'b0;
    device_btn = b;
    repeat (n) @(negedge clk);
  endtask

  // Press b from released; write lands on the edge evt sets.
  task automatic press_seq(input logic [15:0] b,
                           input logic [11:0] wa,
                           input logic [31:0] wd,
                           input logic [15:0] lvl0,
                           input logic [15:0] evt0,
                           input logic [15:0] evt1,
                           input logic [15:0] cnt1);
    device_btn = b;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      io_en = 1'b0;
      if (c == 5)
        rd("lat_lvl5", 12'h070, {16'h0, lvl0});
      if (c == 6) begin
        rd("lat_lvl6", 12'h070, {16'h0, lvl0 | b});
        rd("lat_evt6", 12'h074, {16'h0, evt0});
        io_en = 1'b1;
        io_we = 1'b1;
        io_addr = wa;
        io_write_data = wd;
      end
    end
    @(negedge clk);
    io_en = 1'b0;
    io_we = 1'b0;
    rd("lat_evt7", 12'h074, {16'h0, evt1});
    rd("lat_cnt7", 12'h078, {16'h0, cnt1});
  endtask

  typedef struct {
    logic [15:0] btn;
    int          n;
    logic [15:0] lvl;
    logic [15:0] evt;
    logic [15:0] cnt;
  } vec_t;

  vec_t tab[9];

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0] = '{16'h0000, 3, 16'h0000, 16'h0000, 16'd0};
    tab[1] = '{16'h0004, 10, 16'h0004, 16'h0004, 16'd1};
    tab[2] = '{16'h0000, 10, 16'h0000, 16'h0004, 16'd1};
    tab[3] = '{16'h0001, 3, 16'h0000, 16'h0004, 16'd1};
    tab[4] = '{16'h0000, 10, 16'h0000, 16'h0004, 16'd1};
    tab[5] = '{16'h000A, 10, 16'h000A, 16'h000E, 16'd3};
    tab[6] = '{16'h0000, 10, 16'h0000, 16'h000E, 16'd3};
    tab[7] = '{16'h0015, 10, 16'h0015, 16'h001F, 16'd6};
    tab[8] = '{16'h0000, 10, 16'h0000, 16'h001F, 16'd6};

    rst_n = 1'b0;
    io_en = 1'b0;
    io_we = 1'b0;
    io_addr = '0;
    io_write_data = '0;
    device_btn = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rd("rst_lvl", 12'h070, 32'h0);
    rd("rst_evt", 12'h074, 32'h0);
    rd("rst_cnt", 12'h078, 32'h0);
    rd("rst_unmapped", 12'h07C, 32'h0);

    for (int k = 0; k < 9; k++) begin
      hold(tab[k].btn, tab[k].n);
      rd("tab_lvl", 12'h070, {16'h0, tab[k].lvl});
      rd("tab_evt", 12'h074, {16'h0, tab[k].evt});
      rd("tab_cnt", 12'h078, {16'h0, tab[k].cnt});
      rd("tab_unm", 12'h07C, 32'h0);
    end

    wr(12'h074, 32'h0000_000A);
    rd("w1c_a", 12'h074, 32'h15);
    wr(12'h074, 32'h0000_0005);
    rd("w1c_5", 12'h074, 32'h10);
    press_seq(16'h0010, 12'h074, 32'h10,
              16'h0, 16'h10, 16'h10, 16'd7);
    hold(16'h0, 10);
    press_seq(16'h0002, 12'h078, 32'h0,
              16'h0, 16'h10, 16'h12, 16'd1);
    hold(16'h0, 10);

    wr(12'h070, 32'hFFFF_FFFF);
    wr(12'h07C, 32'hFFFF_FFFF);
    rd("ign_lvl", 12'h070, 32'h0);
    rd("ign_evt", 12'h074, 32'h12);
    rd("ign_cnt", 12'h078, 32'h1);
    io_en = 1'b0;
    io_we = 1'b0;
    io_addr = 12'h078;
    #1;
    n_vec++;
    if (io_read_data !== 32'h0) begin
      n_bad++;
      $display("FAIL idle_rd: got %h want 0", io_read_data);
    end
    io_en = 1'b1;
    io_we = 1'b1;
    io_addr = 12'h070;
    #1;
    n_vec++;
    if (io_read_data !== 32'h0) begin
      n_bad++;
      $display("FAIL wr_rd: got %h want 0", io_read_data);
    end
    io_en = 1'b0;
    io_we = 1'b0;
    @(negedge clk);
    wr(12'h078, 32'h0);
    rd("cnt_clr", 12'h078, 32'h0);

    device_btn = 16'h0008;
    repeat (4) @(negedge clk);
    io_en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd("mid_lvl", 12'h070, 32'h0);
    rd("mid_evt", 12'h074, 32'h0);
    rd("mid_cnt", 12'h078, 32'h0);
    repeat (5) @(negedge clk);
    rd("mid_lvl10", 12'h070, 32'h0);
    @(negedge clk);
    rd("mid_lvl11", 12'h070, 32'h8);
    rd("mid_evt11", 12'h074, 32'h0);
    @(negedge clk);
    rd("mid_evt12", 12'h074, 32'h8);
    rd("mid_cnt12", 12'h078, 32'h1);
    hold(16'h0, 10);

    wr(12'h078, 32'h0);
    for (int k = 0; k < 4095; k++) begin
      hold(16'hFFFF, 4);
      hold(16'h0000, 4);
    end
    hold(16'h0000, 6);
    rd("wrap_fff0", 12'h078, 32'hFFF0);
    hold(16'h7FFF, 10);
    rd("wrap_ffff", 12'h078, 32'hFFFF);
    hold(16'h0000, 10);
    hold(16'h0001, 10);
    rd("wrap_0000", 12'h078, 32'h0000);
    hold(16'h0000, 10);

    for (int k = 0; k < 3000; k++) begin
      int r;
      logic [11:0] a;
      io_en = 1'b0;
      io_we = 1'b0;
      if ($urandom_range(0, 5) == 0)
        device_btn = device_btn ^
                     16'(1 << $urandom_range(0, 15));
      r = $urandom_range(0, 19);
      if (r == 0) begin
        io_en = 1'b1; io_we = 1'b1;
        io_addr = 12'h074;
        io_write_data = $urandom;
      end else if (r == 1) begin
        io_en = 1'b1; io_we = 1'b1;
        io_addr = 12'h078;
        io_write_data = $urandom;
      end else if (r == 2) begin
        io_en = 1'b1; io_we = 1'b1;
        io_addr = r[0] ? 12'h070 : 12'h07C;
        io_write_data = $urandom;
      end else begin
        case ($urandom_range(0, 4))
          0: a = 12'h070;
          1: a = 12'h074;
          2: a = 12'h078;
          3: a = 12'h07C;
          default: a = 12'($urandom);
        endcase
        rd("rand", a, exp_rd(a));
      end
      @(negedge clk);
    end
    io_en = 1'b0;
    io_we = 1'b0;
    rd("end_lvl", 12'h070, exp_rd(12'h070));
    rd("end_evt", 12'h074, exp_rd(12'h074));
    rd("end_cnt", 12'h078, exp_rd(12'h078));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
